// File: rtl/conv_ram_reader_pkg.sv
// Shared geometry, widths, FSM state and beat layout for the convolution RAM reader.
// CONV_READER_ZERO_PAD_EN selects the same-padded sweep instead of the valid-only sweep.
package conv_ram_reader_pkg;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int K       = 3;
  localparam int NUM_KER = 6;
  localparam int DW      = 8;

  localparam int DATA_DEPTH   = IMG_W * IMG_H;
  localparam int WEIGHT_DEPTH = K * K * NUM_KER;
  localparam int DATA_AW      = $clog2(DATA_DEPTH);
  localparam int WEIGHT_AW    = $clog2(WEIGHT_DEPTH);

`ifdef CONV_READER_ZERO_PAD_EN
  localparam int PAD   = (K - 1) / 2;
  localparam int OUT_H = IMG_H;
  localparam int OUT_W = IMG_W;
`else
  localparam int PAD   = 0;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
`endif

  localparam int KER_W = $clog2(NUM_KER);
  localparam int OY_W  = $clog2(OUT_H);
  localparam int OX_W  = $clog2(OUT_W);
  localparam int TAP_W = $clog2(K);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] weight;
    logic          last_tap;
    logic          last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic logic [DATA_AW-1:0] data_addr(input int row, input int col);
    return DATA_AW'(row * IMG_W + col);
  endfunction

  function automatic logic [WEIGHT_AW-1:0] weight_addr(input int ker, input int ky, input int kx);
    return WEIGHT_AW'(ker * K * K + ky * K + kx);
  endfunction

endpackage

// File: rtl/conv_reader_skid_fifo.sv
// Two-entry FIFO that absorbs the synchronous RAM read latency; head is held stable while
// the consumer stalls.
module conv_reader_skid_fifo
  import conv_ram_reader_pkg::*;
#(
  parameter int unsigned Width = BEAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_entry,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/conv_ram_reader.sv
// Sweeps data and weight RAMs in convolution order and streams (pixel, weight) pairs.
// Define CONV_READER_ZERO_PAD_EN for a same-padded sweep with zeroed out-of-image taps.
module conv_ram_reader
  import conv_ram_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_AW-1:0]   data_ram_raddr,
  output logic                 data_ram_ren,
  input  logic [DW-1:0]        data_ram_rdata,
  output logic [WEIGHT_AW-1:0] weight_ram_raddr,
  output logic                 weight_ram_ren,
  input  logic [DW-1:0]        weight_ram_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [DW-1:0]        out_weight,
  output logic                 out_last_tap,
  output logic                 out_last
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [KER_W-1:0] k_q;
  logic [OY_W-1:0]  oy_q;
  logic [OX_W-1:0]  ox_q;
  logic [TAP_W-1:0] ky_q;
  logic [TAP_W-1:0] kx_q;

  // Read issued last cycle; its RAM data is on rdata this cycle.
  logic inflight_q;
  logic tag_pad_q;
  logic tag_last_tap_q;
  logic tag_last_q;

  logic [1:0] fifo_count;
  beat_t      push_beat;
  beat_t      head_beat;
  logic       pop;
  logic       issue;
  logic       pad_tap;
  logic       drain_empty;
  logic [2:0] occupancy;
  logic       kx_wrap, ky_wrap, ox_wrap, oy_wrap, k_wrap;
  logic       last_tap, last_beat;
  int         row, col;

  always_comb begin
    kx_wrap   = (kx_q == TAP_W'(K - 1));
    ky_wrap   = (ky_q == TAP_W'(K - 1));
    ox_wrap   = (ox_q == OX_W'(OUT_W - 1));
    oy_wrap   = (oy_q == OY_W'(OUT_H - 1));
    k_wrap    = (k_q == KER_W'(NUM_KER - 1));
    last_tap  = kx_wrap && ky_wrap;
    last_beat = last_tap && ox_wrap && oy_wrap && k_wrap;
  end

  always_comb begin
    row = int'(oy_q) + int'(ky_q) - PAD;
    col = int'(ox_q) + int'(kx_q) - PAD;
`ifdef CONV_READER_ZERO_PAD_EN
    pad_tap = (row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W);
`else
    pad_tap = 1'b0;
`endif
  end

  // Credit check: at most two beats may be buffered or in flight after this cycle's pop.
  always_comb begin
    pop         = out_valid && out_ready;
    occupancy   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    issue       = (state_q == RUN) && (occupancy < 3'd2);
    drain_empty = !inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
  end

  assign data_ram_ren     = issue && !pad_tap;
  assign weight_ram_ren   = issue;
  assign data_ram_raddr   = pad_tap ? '0 : data_addr(row, col);
  assign weight_ram_raddr = weight_addr(int'(k_q), int'(ky_q), int'(kx_q));

  always_comb begin
    push_beat.data     = tag_pad_q ? '0 : data_ram_rdata;
    push_beat.weight   = weight_ram_rdata;
    push_beat.last_tap = tag_last_tap_q;
    push_beat.last     = tag_last_q;
  end

  conv_reader_skid_fifo #(
    .Width (BEAT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_entry (push_beat),
    .pop        (pop),
    .head       (head_beat),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      k_q            <= '0;
      oy_q           <= '0;
      ox_q           <= '0;
      ky_q           <= '0;
      kx_q           <= '0;
      inflight_q     <= 1'b0;
      tag_pad_q      <= 1'b0;
      tag_last_tap_q <= 1'b0;
      tag_last_q     <= 1'b0;
    end else begin
      inflight_q     <= issue;
      tag_pad_q      <= pad_tap;
      tag_last_tap_q <= last_tap;
      tag_last_q     <= last_beat;
      done_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            k_q     <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (kx_wrap) begin
              kx_q <= '0;
              if (ky_wrap) begin
                ky_q <= '0;
                if (ox_wrap) begin
                  ox_q <= '0;
                  if (oy_wrap) begin
                    oy_q <= '0;
                    k_q  <= k_wrap ? '0 : k_q + 1'b1;
                  end else begin
                    oy_q <= oy_q + 1'b1;
                  end
                end else begin
                  ox_q <= ox_q + 1'b1;
                end
              end else begin
                ky_q <= ky_q + 1'b1;
              end
            end else begin
              kx_q <= kx_q + 1'b1;
            end
            if (last_beat) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign out_valid    = (fifo_count != 2'd0);
  assign out_data     = head_beat.data;
  assign out_weight   = head_beat.weight;
  assign out_last_tap = head_beat.last_tap;
  assign out_last     = head_beat.last;

endmodule

// File: tb/tb_conv_ram_reader.sv
// Scoreboard bench for conv_ram_reader: expected beats are queued at start, a monitor pops them.
module tb_conv_ram_reader;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int KS = 3;
  localparam int NK = 6;
`ifdef CONV_READER_ZERO_PAD_EN
  localparam int PADB = 1;
  localparam int OH   = 8;
  localparam int OW   = 8;
  localparam logic [8:0] REN_PAT = 9'b110110000;
  localparam int B2_D = 0;
  localparam int B4_D = 0;
`else
  localparam int PADB = 0;
  localparam int OH   = 6;
  localparam int OW   = 6;
  localparam logic [8:0] REN_PAT = 9'b111111111;
  localparam int B2_D = 1;
  localparam int B4_D = 8;
`endif
  localparam int BEATS = NK * OH * OW * KS * KS;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] w;
    logic       lt;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [5:0] data_ram_raddr, weight_ram_raddr;
  logic       data_ram_ren, weight_ram_ren;
  logic [7:0] data_ram_rdata, weight_ram_rdata;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data, out_weight;
  logic       out_last_tap, out_last;

  conv_ram_reader dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .data_ram_raddr   (data_ram_raddr),
    .data_ram_ren     (data_ram_ren),
    .data_ram_rdata   (data_ram_rdata),
    .weight_ram_raddr (weight_ram_raddr),
    .weight_ram_ren   (weight_ram_ren),
    .weight_ram_rdata (weight_ram_rdata),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_weight       (out_weight),
    .out_last_tap     (out_last_tap),
    .out_last         (out_last)
  );

  always #5 clk = ~clk;

  // RAM models: data[i]=i, weight[j]=j+100, one cycle read latency.
  logic [7:0] data_mem [64];
  logic [7:0] weight_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      data_mem[i]   = 8'(i);
      weight_mem[i] = 8'(i + 100);
    end
  end
  always @(posedge clk) begin
    if (data_ram_ren) data_ram_rdata <= data_mem[data_ram_raddr];
    if (weight_ram_ren) weight_ram_rdata <= weight_mem[weight_ram_raddr];
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  exp_t sb[$];
  int   ready_mode = 0;
  int   beats, lt_cnt, last_cnt, done_cnt, first_cyc, last_cyc;
  int   issue_cnt, addr_err, ren_err, first_daddr, first_waddr;
  logic [7:0] seen_d [4];
  logic [7:0] seen_w [4];
  logic [8:0] ren_pat;
  logic       prev_stall = 1'b0;
  logic       prev_last_hs = 1'b0;
  logic [7:0] pv_d, pv_w;
  logic [1:0] pv_f;

  task automatic clear_stats();
    beats = 0; lt_cnt = 0; last_cnt = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0;
    issue_cnt = 0; addr_err = 0; ren_err = 0; first_daddr = -1; first_waddr = -1;
    ren_pat = '0;
    for (int i = 0; i < 4; i++) begin
      seen_d[i] = 8'hxx;
      seen_w[i] = 8'hxx;
    end
  endtask

  task automatic push_expected();
    int   r, c;
    exp_t e;
    for (int k = 0; k < NK; k++)
      for (int oy = 0; oy < OH; oy++)
        for (int ox = 0; ox < OW; ox++)
          for (int ky = 0; ky < KS; ky++)
            for (int kx = 0; kx < KS; kx++) begin
              r    = oy + ky - PADB;
              c    = ox + kx - PADB;
              e.d  = (r < 0 || r >= IH || c < 0 || c >= IW) ? 8'd0 : 8'(r * IW + c);
              e.w  = 8'(k * KS * KS + ky * KS + kx + 100);
              e.lt = (ky == KS - 1) && (kx == KS - 1);
              e.l  = e.lt && (ox == OW - 1) && (oy == OH - 1) && (k == NK - 1);
              sb.push_back(e);
            end
  endtask

  // Monitor: address/ren observation, stall stability, done timing, scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    if (weight_ram_ren) begin
      if (issue_cnt == 0) begin
        first_daddr = int'(data_ram_raddr);
        first_waddr = int'(weight_ram_raddr);
      end
      if (issue_cnt < 9) ren_pat[issue_cnt] = data_ram_ren;
      if (int'(weight_ram_raddr) > 53) addr_err++;
`ifndef CONV_READER_ZERO_PAD_EN
      if (!data_ram_ren) ren_err++;
`endif
      issue_cnt++;
    end
    if (data_ram_ren && !weight_ram_ren) ren_err++;
    if (done) begin
      done_cnt++;
      chk("done_after_last_beat", prev_last_hs, 1);
    end
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, pv_d);
      chk("stall_weight", out_weight, pv_w);
      chk("stall_flags", {out_last_tap, out_last}, pv_f);
    end
    hs = out_valid && out_ready;
    if (hs) begin
      if (beats < 4) begin
        seen_d[beats] = out_data;
        seen_w[beats] = out_weight;
      end
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      chk("beat_in_scoreboard", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_weight", out_weight, e.w);
        chk("beat_flags", {out_last_tap, out_last}, {e.lt, e.l});
      end
      beats++;
      if (out_last_tap) lt_cnt++;
      if (out_last) last_cnt++;
    end
    prev_last_hs = hs && out_last;
    prev_stall   = out_valid && !out_ready && !rst;
    pv_d = out_data;
    pv_w = out_weight;
    pv_f = {out_last_tap, out_last};
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic pulse_start(input bit accept);
    @(posedge clk);
    #1 start = 1'b1;
    if (accept) push_expected();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("done_seen_in_time", done_cnt != d0, 1);
  endtask

  task automatic check_sweep(input string tag);
    chk({tag, "_beats"}, beats, BEATS);
    chk({tag, "_last_taps"}, lt_cnt, BEATS / (KS * KS));
    chk({tag, "_last_count"}, last_cnt, 1);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_addr_range"}, addr_err, 0);
    chk({tag, "_ren_pairing"}, ren_err, 0);
  endtask

  initial begin
    int n;
    int d0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_ren", data_ram_ren, 0);
    chk("rst_weight_ren", weight_ram_ren, 0);
    chk("rst_data_addr", data_ram_raddr, 0);
    chk("rst_weight_addr", weight_ram_raddr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_weight", out_weight, 0);
    chk("rst_flags", {out_last_tap, out_last}, 0);

    // Full-rate sweep.
    clear_stats();
    pulse_start(1);
    @(negedge clk);
    chk("c1_busy", busy, 1);
    chk("c1_weight_ren", weight_ram_ren, 1);
    chk("c1_weight_addr", weight_ram_raddr, 0);
    chk("c1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("c2_out_valid", out_valid, 0);
    @(negedge clk);
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_data", out_data, 0);
    chk("c3_out_weight", out_weight, 100);
    wait_done(6000);
    check_sweep("full");
    chk("beat2_data", seen_d[1], B2_D);
    chk("beat2_weight", seen_w[1], 101);
    chk("beat4_data", seen_d[3], B4_D);
    chk("beat4_weight", seen_w[3], 103);
    chk("contiguous_span", last_cyc - first_cyc + 1, BEATS);
    chk("first_pixel_ren_pattern", ren_pat, REN_PAT);

    // Random backpressure.
    clear_stats();
    ready_mode = 1;
    pulse_start(1);
    wait_done(20000);
    check_sweep("random");

    // Consumer stalled: only two read pairs may be outstanding.
    clear_stats();
    ready_mode = 2;
    pulse_start(1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("stall_first_valid", out_valid, 1);
    repeat (10) @(negedge clk);
    #2;
    chk("stall_issue_count", issue_cnt, 2);
    chk("stall_no_beats", beats, 0);
    ready_mode = 0;
    wait_done(6000);
    check_sweep("stall");

    // Start during RUN is ignored; a start after done repeats the sweep.
    clear_stats();
    pulse_start(1);
    repeat (50) @(posedge clk);
    pulse_start(0);
    wait_done(6000);
    chk("restart_ignored_beats", beats, BEATS);
    chk("restart_ignored_done", done_cnt, 1);
    chk("restart_ignored_sb", sb.size(), 0);
    clear_stats();
    pulse_start(1);
    wait_done(6000);
    check_sweep("repeat");
    chk("repeat_first_waddr", first_waddr, 0);
    chk("repeat_first_data", seen_d[0], 0);
    chk("repeat_first_weight", seen_w[0], 100);

    // Reset mid-sweep aborts without done.
    clear_stats();
    pulse_start(1);
    n = 0;
    while (beats < 500 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("abort_reached_500", beats >= 500, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_data_ren", data_ram_ren, 0);
    chk("abort_weight_ren", weight_ram_ren, 0);
    sb.delete();
    #2;
    d0 = done_cnt;
    n  = beats;
    repeat (20) @(negedge clk);
    #2;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_beats", beats, n);
    clear_stats();
    pulse_start(1);
    wait_done(6000);
    check_sweep("after_abort");
    chk("after_abort_first_data", seen_d[0], 0);
    chk("after_abort_first_weight", seen_w[0], 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
